// File: rtl/drum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drum_pkg
//  Purpose  : Shared constants and types for the drum step sequencer: track
//             count, pattern length, sequencer state encoding and the track
//             index assignments used on wr_track / trig.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package drum_pkg;

  localparam int unsigned NUM_TRACKS = 4;
  localparam int unsigned NUM_STEPS  = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  localparam logic [1:0] TRK_SNARE = 2'd0;
  localparam logic [1:0] TRK_KICK  = 2'd1;
  localparam logic [1:0] TRK_HAT   = 2'd2;
  localparam logic [1:0] TRK_CLAP  = 2'd3;

endpackage : drum_pkg
`default_nettype wire

// File: rtl/bpm_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bpm_tick_gen
//  Purpose  : Phase accumulator that turns a tempo in BPM into one-cycle step
//             ticks. Each enabled cycle adds bpm; crossing TH = CLK_HZ*60
//             emits a tick and wraps the remainder, so the long-run tick rate
//             is exactly bpm ticks per minute.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous active-high clear of the accumulator
//             en    - accumulate when high; accumulator held at 0 when low
//             bpm   - tempo increment per cycle (0 = stall)
//             tick  - combinational, high in the cycle whose edge wraps acc
//  Revision : 1.0  initial release
// ============================================================================
module bpm_tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] bpm,
  output logic       tick
);

  localparam logic [31:0] TH = 32'(64'(CLK_HZ) * 64'd60);

  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [32:0] sum;

  // One extra bit keeps the compare exact even when TH sits near 2^32.
  assign sum  = {1'b0, acc_q} + {25'd0, bpm};
  assign tick = en && (sum >= {1'b0, TH});
  // bpm < TH, so one subtraction always lands the remainder below TH.
  assign acc_d = tick ? 32'(sum - {1'b0, TH}) : sum[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end else begin
      acc_q <= '0;
    end
  end

endmodule : bpm_tick_gen
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : step_sequencer
//  Purpose  : Four-track drum step sequencer. Holds one 8-step pattern per
//             track, advances the step on each tempo tick while playing and
//             emits registered one-cycle trigger pulses, masked by mute.
//  Ports    : clk        - clock, rising edge
//             reset      - synchronous active-high reset
//             bpm        - tempo, one step per beat, 0 = stall
//             start/stop - one-cycle playback requests (stop wins)
//             wr_en, wr_track, wr_pattern - pattern write port
//             mute       - per-track trigger suppression mask
//             trig       - per-track one-cycle trigger pulses
//             step       - current step index
//             playing    - high while in PLAY
//             bar_start  - one-cycle pulse whenever step 0 is emitted
//  Revision : 1.0  initial release
// ============================================================================
module step_sequencer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned NUM_STEPS = drum_pkg::NUM_STEPS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bpm,
  input  logic       start,
  input  logic       stop,
  input  logic       wr_en,
  input  logic [1:0] wr_track,
  input  logic [7:0] wr_pattern,
  input  logic [3:0] mute,
  output logic [3:0] trig,
  output logic [2:0] step,
  output logic       playing,
  output logic       bar_start
);

  import drum_pkg::*;

  state_e     state_q;
  logic [2:0] step_q;
  logic [3:0] trig_q;
  logic       bar_q;
  logic [7:0] pattern_q [NUM_TRACKS];

  logic [2:0] step_d;
  logic [3:0] hit_next;
  logic [3:0] hit_first;
  logic       tick;
  logic       acc_clr;
  logic       in_play;

  assign in_play = (state_q == PLAY);
  assign step_d  = (step_q == 3'(NUM_STEPS - 1)) ? 3'd0 : step_q + 3'd1;

  // Patterns are read from the registered copy, so a write landing on the
  // same edge as a trigger only affects later steps.
  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
    assign hit_next[t]  = pattern_q[t][step_d];
    assign hit_first[t] = pattern_q[t][0];
  end

  // Start and stop both restart the phase from zero; the accumulator also
  // sits at zero whenever the sequencer is idle.
  assign acc_clr = reset | start | stop;

  bpm_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .reset (acc_clr),
    .en    (in_play),
    .bpm   (bpm),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      trig_q  <= '0;
      bar_q   <= 1'b0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
        pattern_q[i] <= '0;
      end
    end else begin
      // Pulses default low; only an emitted step raises them for one cycle.
      trig_q <= '0;
      bar_q  <= 1'b0;
      if (wr_en) begin
        pattern_q[wr_track] <= wr_pattern;
      end
      if (stop) begin
        state_q <= IDLE;
        step_q  <= '0;
      end else if (start) begin
        state_q <= PLAY;
        step_q  <= '0;
        trig_q  <= hit_first & ~mute;
        bar_q   <= 1'b1;
      end else if (in_play && tick) begin
        step_q <= step_d;
        trig_q <= hit_next & ~mute;
        bar_q  <= (step_d == 3'd0);
      end
    end
  end

  assign trig      = trig_q;
  assign step      = step_q;
  assign playing   = in_play;
  assign bar_start = bar_q;

endmodule : step_sequencer
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_sequencer
//  Purpose  : Directed self-checking bench for step_sequencer with
//             CLK_HZ = 2 (TH = 120). Inputs are driven and outputs sampled
//             1 time unit after each rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bpm;
  logic       start;
  logic       stop;
  logic       wr_en;
  logic [1:0] wr_track;
  logic [7:0] wr_pattern;
  logic [3:0] mute;
  logic [3:0] trig;
  logic [2:0] step;
  logic       playing;
  logic       bar_start;

  int n_vec = 0;
  int n_err = 0;

  step_sequencer #(
    .CLK_HZ (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bpm        (bpm),
    .start      (start),
    .stop       (stop),
    .wr_en      (wr_en),
    .wr_track   (wr_track),
    .wr_pattern (wr_pattern),
    .mute       (mute),
    .trig       (trig),
    .step       (step),
    .playing    (playing),
    .bar_start  (bar_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_trig, input logic [2:0] e_step,
                           input logic e_play, input logic e_bar);
    check({tag, ".trig"}, 32'(trig), 32'(e_trig));
    check({tag, ".step"}, 32'(step), 32'(e_step));
    check({tag, ".playing"}, 32'(playing), 32'(e_play));
    check({tag, ".bar_start"}, 32'(bar_start), 32'(e_bar));
  endtask

  // Step sequence after restart at bpm 40, with bpm switched to 60 after k=4.
  logic [2:0] s2_step [1:10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};

  initial begin
    reset = 1'b1; bpm = 8'd0; start = 1'b0; stop = 1'b0;
    wr_en = 1'b0; wr_track = 2'd0; wr_pattern = 8'h00; mute = 4'h0;
    cyc(); cyc();
    check_out("reset", 4'h0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();
    check_out("idle", 4'h0, 3'd0, 1'b0, 1'b0);

    // Scenario 1: kick = 0000_0101, bpm 120 -> one step per cycle.
    wr_en = 1'b1; wr_track = 2'd1; wr_pattern = 8'b0000_0101;
    cyc();
    wr_en = 1'b0;
    bpm = 8'd120; start = 1'b1;
    cyc();
    start = 1'b0;
    check_out("s1.k0", 4'b0010, 3'd0, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check_out($sformatf("s1.k%0d", k),
                ((k % 8 == 0) || (k % 8 == 2)) ? 4'b0010 : 4'b0000,
                3'(k % 8), 1'b1, (k % 8 == 0));
    end

    // Scenario 2: restart at bpm 40 (tick every 3), then bpm 60 (every 2).
    bpm = 8'd40; start = 1'b1;
    cyc();
    start = 1'b0;
    check_out("s2.k0", 4'b0010, 3'd0, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("s2.k%0d.step", k), 32'(step), 32'(s2_step[k]));
      check($sformatf("s2.k%0d.trig", k), 32'(trig), (k == 6) ? 32'h2 : 32'h0);
      if (k == 4) bpm = 8'd60;
    end

    // Scenario 3: start+stop together from PLAY, then from IDLE.
    bpm = 8'd120; start = 1'b1; stop = 1'b1;
    cyc();
    check_out("s3.play", 4'h0, 3'd0, 1'b0, 1'b0);
    cyc();
    check_out("s3.idle", 4'h0, 3'd0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    cyc();
    check_out("s3.after", 4'h0, 3'd0, 1'b0, 1'b0);

    // Scenario 4: snare = FF, muted then unmuted while playing.
    wr_en = 1'b1; wr_track = 2'd0; wr_pattern = 8'hFF;
    cyc();
    wr_en = 1'b0;
    mute = 4'b0001; start = 1'b1;
    cyc();
    start = 1'b0;
    check_out("s4.s0", 4'b0010, 3'd0, 1'b1, 1'b1);
    cyc();
    check_out("s4.s1", 4'b0000, 3'd1, 1'b1, 1'b0);
    mute = 4'b0000;
    cyc();
    check_out("s4.s2", 4'b0011, 3'd2, 1'b1, 1'b0);
    cyc();
    check_out("s4.s3", 4'b0001, 3'd3, 1'b1, 1'b0);

    // Scenario 5: hat written 00->10 on the edge that emits step 4.
    wr_en = 1'b1; wr_track = 2'd2; wr_pattern = 8'h10;
    cyc();
    wr_en = 1'b0;
    check_out("s5.s4", 4'b0001, 3'd4, 1'b1, 1'b0);
    for (int k = 5; k <= 12; k++) begin
      cyc();
      check_out($sformatf("s5.k%0d", k),
                {1'b0, (k % 8 == 4), ((k % 8 == 0) || (k % 8 == 2)), 1'b1},
                3'(k % 8), 1'b1, (k % 8 == 0));
    end

    // Scenario 6: reset at step 5, then restart with cleared patterns.
    cyc();
    check("s6.step5", 32'(step), 32'd5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_out("s6.reset", 4'h0, 3'd0, 1'b0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_out("s6.s0", 4'h0, 3'd0, 1'b1, 1'b1);
    cyc();
    cyc();
    check_out("s6.s2", 4'h0, 3'd2, 1'b1, 1'b0);

    // bpm = 0 stalls the step; stop then returns to IDLE.
    bpm = 8'd0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_out($sformatf("stall%0d", k), 4'h0, 3'd2, 1'b1, 1'b0);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_out("stop", 4'h0, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_step_sequencer
`default_nettype wire

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, the clk frequency in Hz; the step threshold is TH = CLK_HZ*60 and SHALL be held in 32 bits.
REQ-002 Parameter NUM_STEPS, default 8, the pattern length in steps.
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bpm  input  8  tempo in beats per minute; one step per beat; 0 = stall.
REQ-006 start  input  1  one-cycle request to begin playback from step 0.
REQ-007 stop  input  1  one-cycle request to end playback.
REQ-008 wr_en  input  1  write strobe for a track pattern.
REQ-009 wr_track  input  2  index of the track to write (0 = snare, 1 = kick, 2 = hat, 3 = clap).
REQ-010 wr_pattern  input  8  new pattern; bit n = hit on step n.
REQ-011 mute  input  4  per-track mute mask; 1 = suppress that track's triggers.
REQ-012 trig  output  4  per-track one-cycle trigger pulses to the drum voices.
REQ-013 step  output  3  index of the current step.
REQ-014 playing  output  1  high while in state PLAY.
REQ-015 bar_start  output  1  one-cycle pulse each time step 0 is emitted.

Function
REQ-016 The block SHALL have two states, IDLE and PLAY; playing = (state == PLAY).
REQ-017 In IDLE, start SHALL move to PLAY and load step = 0 and acc = 0; trig = pattern[t][0] & ~mute[t] and bar_start = 1 SHALL be asserted on the following cycle (latency 1).
REQ-018 In PLAY, start SHALL restart the block exactly as in REQ-017.
REQ-019 In PLAY, stop SHALL return the block to IDLE with step = 0, and trig SHALL be 0 from the next cycle.
REQ-020 When start and stop are asserted in the same cycle, stop SHALL win in either state.
REQ-021 Tick generation: each PLAY cycle, when acc + bpm < TH, acc SHALL take the value acc + bpm and no tick SHALL be generated.
REQ-022 Tick generation: when acc + bpm >= TH, acc SHALL take the value acc + bpm - TH and a tick SHALL be generated; a single subtraction SHALL suffice because bpm < TH.
REQ-023 On a tick, step SHALL advance modulo NUM_STEPS (7 -> 0 wrap), and on the next cycle trig SHALL equal pattern[t][new step] & ~mute for each track.
REQ-024 bar_start SHALL pulse when a tick wraps step to 0.
REQ-025 trig and bar_start SHALL be registered outputs, high for exactly 1 cycle per emitted step and 0 at all other times.
REQ-026 With bpm = 0, acc and step SHALL hold and no trig SHALL occur.
REQ-027 A bpm change SHALL take effect on the next cycle, without clearing acc.
REQ-028 wr_en SHALL update pattern[wr_track] at the clock edge in either state.
REQ-029 A trigger evaluated in the same cycle as a write to its track SHALL use the old pattern value.
REQ-030 mute SHALL be sampled in the cycle the trigger is evaluated.
REQ-031 In IDLE, acc SHALL hold 0 and trig and bar_start SHALL remain 0.

Reset
REQ-032 While reset is high, the state SHALL be IDLE.
REQ-033 While reset is high, step, acc, trig, bar_start and playing SHALL be 0, and all four patterns SHALL be 8'h00.
REQ-034 Reset SHALL take priority over start, stop and wr_en, including when asserted mid-playback.

Structure
REQ-035 The NUM_TRACKS (4) and NUM_STEPS (8) constants, the IDLE/PLAY state encoding and the track index constants SHALL reside in the shared package drum_pkg.
REQ-036 The phase accumulator (acc, TH compare and tick) SHALL be a sub-module bpm_tick_gen with ports clk, reset, en, bpm and tick.

Verification (CLK_HZ = 2, so TH = 120)
REQ-037 Scenario 1: write kick = 8'b0000_0101, bpm = 120, pulse start -> trig[1] high on cycle 1 (step 0) and on the cycle after the second tick (step 2); one step per cycle; bar_start again 8 ticks later.
REQ-038 Scenario 2: bpm = 40 -> ticks exactly every 3 cycles; change bpm to 60 mid-play -> ticks every 2 cycles from the next accumulation, with no dropped or duplicated step.
REQ-039 Scenario 3: pulse start and stop in the same cycle from IDLE, then again from PLAY -> state IDLE, trig never asserted, step = 0.
REQ-040 Scenario 4: snare pattern = 8'hFF, mute = 4'b0001 while playing -> trig[0] stays 0; clearing mute -> trig[0] resumes on the next emitted step.
REQ-041 Scenario 5: overwrite hat pattern from 8'h00 to 8'h10 in the cycle step 4 is evaluated -> no hat trigger on that step; hat triggers on step 4 of the next bar.
REQ-042 Scenario 6: assert reset mid-PLAY at step 5 -> next cycle playing = 0, step = 0, trig = 0, all patterns 0; then start with bpm = 120 -> no trig asserted.
